// File: rtl/all_pkgs.sv
// Shared core definitions: datapath width, RV32 opcodes, decode-stage state
// encoding and the per-opcode operand-use table.
package all_pkgs;

    localparam int WIDTH = 32;

    localparam logic [6:0] R_TYPE     = 7'b0110011;
    localparam logic [6:0] I_TYPE     = 7'b0010011;
    localparam logic [6:0] I_LOAD     = 7'b0000011;
    localparam logic [6:0] S_TYPE     = 7'b0100011;
    localparam logic [6:0] B_TYPE     = 7'b1100011;
    localparam logic [6:0] J_TYPE     = 7'b1101111;
    localparam logic [6:0] JALR_TYPE  = 7'b1100111;
    localparam logic [6:0] LUI_TYPE   = 7'b0110111;
    localparam logic [6:0] AUIPC_TYPE = 7'b0010111;

    typedef enum logic [1:0] {EMPTY, READY, HAZARD} dec_state_e;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } op_use_t;

    function automatic op_use_t op_use(input logic [6:0] opc);
        op_use_t u;
        u = '0;
        case (opc)
            R_TYPE:                     u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
            I_TYPE, I_LOAD, JALR_TYPE:  u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            S_TYPE, B_TYPE:             u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
            J_TYPE, LUI_TYPE, AUIPC_TYPE: u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            default:                    u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/decoder.sv
// Combinational RV32 field/immediate decoder; unknown opcodes yield imm 0
// and no operand use.
module decoder
    import all_pkgs::*;
(
    input  logic [WIDTH-1:0] instr,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] imm,
    output op_use_t          use_o
);

    always_comb begin
        rs1   = instr[19:15];
        rs2   = instr[24:20];
        rd    = instr[11:7];
        use_o = op_use(instr[6:0]);
        imm   = '0;
        case (instr[6:0])
            I_TYPE, I_LOAD, JALR_TYPE:
                imm = {{(WIDTH-12){instr[31]}}, instr[31:20]};
            S_TYPE:
                imm = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE:
                imm = {{(WIDTH-13){instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            J_TYPE:
                imm = {{(WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            LUI_TYPE, AUIPC_TYPE:
                imm = {instr[31:12], 12'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode stage: IF/ID register, register scoreboard with RAW blocking,
// EX issue handshake, flush squash and saturating stall counter.
module decode_issue_ctrl
    import all_pkgs::*;
#(
    parameter int NREG   = 32,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [WIDTH-1:0]  if_instr,
    input  logic [WIDTH-1:0]  if_pc,
    output logic              if_ready,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [WIDTH-1:0]  issue_instr,
    output logic [WIDTH-1:0]  issue_pc,
    output logic [WIDTH-1:0]  issue_imm,
    output logic [4:0]        issue_rs1,
    output logic [4:0]        issue_rs2,
    output logic [4:0]        issue_rd,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic              flush,
    output logic [SCNT_W-1:0] stall_cycles
);

    dec_state_e        state_q, state_d;
    logic [WIDTH-1:0]  instr_q, instr_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [NREG-1:0]   pending_q, pending_d, pend_wb;
    logic [SCNT_W-1:0] stall_q, stall_d;
    logic              held, hazard, issue, accept;
    op_use_t           dec_use, new_use;

    function automatic logic raw(input logic [NREG-1:0] pend,
                                 input logic [4:0] a, input logic [4:0] b,
                                 input op_use_t u);
        return (u.rs1 && a != '0 && pend[a]) || (u.rs2 && b != '0 && pend[b]);
    endfunction

    decoder u_decoder (
        .instr (instr_q),
        .rs1   (issue_rs1),
        .rs2   (issue_rs2),
        .rd    (issue_rd),
        .imm   (issue_imm),
        .use_o (dec_use)
    );

    assign issue_instr  = instr_q;
    assign issue_pc     = pc_q;
    assign stall_cycles = stall_q;

    always_comb begin
        held = (state_q != EMPTY);

        // Writeback clears before the hazard check (write-through regfile).
        pend_wb = pending_q;
        if (wb_valid)
            pend_wb[wb_rd] = 1'b0;

        hazard      = raw(pend_wb, issue_rs1, issue_rs2, dec_use);
        issue_valid = held && !hazard && !flush;
        issue       = issue_valid && issue_ready;
        if_ready    = !held || issue || flush;
        accept      = if_valid && if_ready && !flush;

        // Set after clear so a same-index issue wins over writeback.
        pending_d = pend_wb;
        if (issue && dec_use.rd && issue_rd != '0)
            pending_d[issue_rd] = 1'b1;

        new_use = op_use(if_instr[6:0]);
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        // HAZARD/READY is classified against next cycle's scoreboard.
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            instr_d = if_instr;
            pc_d    = if_pc;
            state_d = raw(pending_d, if_instr[19:15], if_instr[24:20], new_use)
                      ? HAZARD : READY;
        end else if (issue) begin
            state_d = EMPTY;
        end else if (held) begin
            state_d = raw(pending_d, issue_rs1, issue_rs2, dec_use) ? HAZARD : READY;
        end

        stall_d = stall_q;
        if (state_q == HAZARD && !flush && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            instr_q   <= '0;
            pc_q      <= '0;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
        end
    end

endmodule
